// File: rtl/fifo_stream_reader.sv
// FWFT FIFO to ready/valid stream adapter with output + skid buffering and packet truncation.
// Optional statistics counters are enabled by defining FIFO_READER_STATS_EN.
module fifo_stream_reader #(
    parameter int DW       = 16,
    parameter int LGMAXLEN = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_rd_empty,
    input  logic [DW:0]   i_rd_data,
    output logic          o_rd,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic          o_trunc,
    output logic [31:0]   o_pkt_count,
    output logic [31:0]   o_drop_count
);

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    // Value of the length counter just before the final allowed word is popped.
    localparam logic [LGMAXLEN:0] LEN_LAST = {1'b0, {LGMAXLEN{1'b1}}};

    state_t            state, state_next;
    logic [LGMAXLEN:0] len, len_next;
    logic              skid_valid;
    logic [DW-1:0]     skid_data;
    logic              skid_last;

    logic word_last;
    logic pass_pop;
    logic trunc_hit;
    logic out_free;

    assign word_last = i_rd_data[DW];
    assign out_free  = !o_valid || i_ready;
    assign pass_pop  = o_rd && (state == PASS);
    assign trunc_hit = pass_pop && !word_last && (len == LEN_LAST);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        len_next   = len;
        o_rd       = 1'b0;
        if (i_reset_n && !i_rd_empty)
            o_rd = (state == DROP) || !skid_valid;
        case (state)
            PASS: begin
                if (o_rd) begin
                    if (word_last)
                        len_next = '0;
                    else begin
                        len_next = len + 1'b1;
                        if (len == LEN_LAST)
                            state_next = DROP;
                    end
                end
            end
            DROP: begin
                if (o_rd && word_last) begin
                    state_next = PASS;
                    len_next   = '0;
                end
            end
            default: state_next = PASS;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= PASS;
            len        <= '0;
            o_valid    <= 1'b0;
            skid_valid <= 1'b0;
            o_trunc    <= 1'b0;
        end else begin
            state   <= state_next;
            len     <= len_next;
            o_trunc <= trunc_hit;
            if (out_free) begin
                // A pending skid word always wins; in PASS a pop is impossible while it is held.
                o_valid    <= skid_valid || pass_pop;
                skid_valid <= 1'b0;
            end else if (pass_pop) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are qualified by o_valid / skid_valid.
    always_ff @(posedge i_clk) begin
        if (out_free) begin
            if (skid_valid) begin
                o_data <= skid_data;
                o_last <= skid_last;
            end else if (pass_pop) begin
                o_data <= i_rd_data[DW-1:0];
                o_last <= word_last || trunc_hit;
            end
        end else if (pass_pop) begin
            skid_data <= i_rd_data[DW-1:0];
            skid_last <= word_last || trunc_hit;
        end
    end

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pkt_count  <= '0;
            o_drop_count <= '0;
        end else begin
            if (o_valid && i_ready && o_last)
                o_pkt_count <= o_pkt_count + 32'd1;
            if (o_rd && (state == DROP))
                o_drop_count <= o_drop_count + 32'd1;
        end
    end
`else
    assign o_pkt_count  = '0;
    assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader (DW=8, LGMAXLEN=2): directed cases plus random packets.
module tb_fifo_stream_reader;

    localparam int DW     = 8;
    localparam int MAXLEN = 4;
`ifdef FIFO_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          i_clk;
    logic          i_reset_n;
    logic          i_rd_empty;
    logic [DW:0]   i_rd_data;
    logic          o_rd;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_trunc;
    logic [31:0]   o_pkt_count;
    logic [31:0]   o_drop_count;

    fifo_stream_reader #(.DW(DW), .LGMAXLEN(2)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_rd_empty   (i_rd_empty),
        .i_rd_data    (i_rd_data),
        .o_rd         (o_rd),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_last       (o_last),
        .o_trunc      (o_trunc),
        .o_pkt_count  (o_pkt_count),
        .o_drop_count (o_drop_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [DW:0] fifo_q[$];
    logic [DW:0] exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  pkt_idx = 0;
    bit  in_drop = 0;
    bit  exp_trunc = 0;
    int  exp_pkt = 0;
    int  exp_drop = 0;
    int  pops = 0;
    int  xfers = 0;
    int  trunc_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet rules: words 1..MAXLEN forwarded, MAXLEN-th without last is truncated, rest dropped.
    task automatic model_pop(input logic [DW:0] w);
        if (in_drop) begin
            exp_drop++;
            if (w[DW]) begin
                in_drop = 0;
                pkt_idx = 0;
            end
        end else begin
            pkt_idx++;
            if (w[DW]) begin
                exp_q.push_back(w);
                pkt_idx = 0;
            end else if (pkt_idx == MAXLEN) begin
                exp_q.push_back({1'b1, w[DW-1:0]});
                exp_trunc = 1;
                in_drop   = 1;
            end else begin
                exp_q.push_back(w);
            end
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, advance to next negedge.
    task automatic cycle(input bit rdy, input bit allow);
        logic [DW:0] e;
        bit popped;
        popped  = 0;
        i_ready = rdy;
        if (allow && fifo_q.size() > 0) begin
            i_rd_empty = 1'b0;
            i_rd_data  = fifo_q[0];
        end else begin
            i_rd_empty = 1'b1;
            i_rd_data  = '0;
        end
        #1;
        check("trunc", {31'd0, o_trunc}, {31'd0, exp_trunc});
        check("pkt_count", o_pkt_count, STATS ? exp_pkt : 0);
        check("drop_count", o_drop_count, STATS ? exp_drop : 0);
        if (i_rd_empty) check("rd_when_empty", {31'd0, o_rd}, 32'd0);
        if (o_trunc) trunc_seen++;
        exp_trunc = 0;
        if (o_valid && i_ready) begin
            xfers++;
            if (exp_q.size() == 0) begin
                check("xfer_extra", {23'd0, o_last, o_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("xfer", {23'd0, o_last, o_data}, {23'd0, e});
                if (e[DW]) exp_pkt++;
            end
        end
        if (o_rd && !i_rd_empty) begin
            pops++;
            model_pop(fifo_q[0]);
            popped = 1;
        end
        @(posedge i_clk);
        if (popped) void'(fifo_q.pop_front());
        @(negedge i_clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || o_valid) && n < 500) begin
            cycle(1, 1);
            n++;
        end
        check(tag, fifo_q.size() + exp_q.size() + int'(o_valid), 0);
    endtask

    task automatic push_pkt(input logic [DW-1:0] first, input int len);
        for (int i = 0; i < len; i++)
            fifo_q.push_back({(i == len - 1), first + DW'(i)});
    endtask

    initial begin
        int p0;
        int x0;
        int t0;
        int n;
        int len;
        i_reset_n  = 1'b0;
        i_ready    = 1'b0;
        i_rd_empty = 1'b1;
        i_rd_data  = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_rd", {31'd0, o_rd}, 32'd0);
        check("rst_trunc", {31'd0, o_trunc}, 32'd0);
        check("rst_pkt", o_pkt_count, 32'd0);
        check("rst_drop", o_drop_count, 32'd0);
        i_reset_n = 1'b1;

        // Three-word packet streams on consecutive cycles after one cycle of latency.
        fifo_q.push_back(9'h011);
        fifo_q.push_back(9'h022);
        fifo_q.push_back(9'h133);
        x0 = xfers;
        t0 = trunc_seen;
        cycle(1, 1);
        check("req034_latency", xfers - x0, 0);
        repeat (3) cycle(1, 1);
        check("req034_xfers", xfers - x0, 3);
        check("req034_idle", {31'd0, o_valid}, 32'd0);
        check("req034_notrunc", trunc_seen - t0, 0);

        // Six-word packet truncated after four.
        push_pkt(8'h01, 6);
        t0 = trunc_seen;
        drain("req035_drain");
        check("req035_trunc", trunc_seen - t0, 1);
        check("req035_drop", o_drop_count, STATS ? 32'd2 : 32'd0);

        // Back-pressure: only output + skid fill while stalled.
        push_pkt(8'hB1, 3);
        p0 = pops;
        repeat (5) cycle(0, 1);
        check("req036_pops", pops - p0, 2);
        #1;
        check("req036_rd_stalled", {31'd0, o_rd}, 32'd0);
        @(negedge i_clk);
        drain("req036_drain");

        // Truncation while stalled: discard words still popped.
        push_pkt(8'hC1, 6);
        repeat (3) cycle(1, 1);
        p0 = pops;
        t0 = trunc_seen;
        repeat (3) cycle(0, 1);
        check("req037_pops", pops - p0, 3);
        check("req037_trunc", trunc_seen - t0, 1);
        drain("req037_drain");

        // Exact-length packet then a normal one.
        push_pkt(8'hD1, 4);
        push_pkt(8'hE1, 2);
        t0 = trunc_seen;
        drain("req039_drain");
        check("req039_notrunc", trunc_seen - t0, 0);

        // Reset mid-packet with words held in output and skid.
        fifo_q.push_back(9'h0A1);
        fifo_q.push_back(9'h0A2);
        fifo_q.push_back(9'h0A3);
        fifo_q.push_back(9'h0A4);
        fifo_q.push_back(9'h0A5);
        fifo_q.push_back(9'h1A6);
        repeat (2) cycle(0, 1);
        check("req038_pre_valid", {31'd0, o_valid}, 32'd1);
        i_rd_empty = 1'b0;
        i_rd_data  = fifo_q[0];
        i_reset_n  = 1'b0;
        #1;
        check("req038_valid", {31'd0, o_valid}, 32'd0);
        check("req038_rd", {31'd0, o_rd}, 32'd0);
        check("req038_trunc", {31'd0, o_trunc}, 32'd0);
        check("req038_pkt", o_pkt_count, 32'd0);
        check("req038_drop", o_drop_count, 32'd0);
        exp_q.delete();
        pkt_idx   = 0;
        in_drop   = 0;
        exp_trunc = 0;
        exp_pkt   = 0;
        exp_drop  = 0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        t0 = trunc_seen;
        drain("req038_drain");
        check("req038_notrunc", trunc_seen - t0, 0);

        // Random packets with random back-pressure and FIFO bubbles.
        for (int p = 0; p < 30; p++) begin
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++)
                fifo_q.push_back({(i == len - 1), 8'($urandom)});
        end
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8);
            n++;
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DW, default 16: payload bits per FIFO word, excluding the last flag.
REQ-002 Parameter LGMAXLEN, default 8: maximum packet length is (1<<LGMAXLEN) words.
REQ-003 Port i_clk  input  1  single clock; every register is in this domain.
REQ-004 Port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port i_rd_empty  input  1  FIFO empty flag; when low, i_rd_data is valid (first-word-fall-through).
REQ-006 Port i_rd_data  input  DW+1  FIFO word; bit DW is the last flag, bits DW-1:0 are payload.
REQ-007 Port o_rd  output  1  FIFO pop strobe; one word is consumed per cycle that o_rd is high and i_rd_empty is low.
REQ-008 Port o_valid  output  1  stream word valid.
REQ-009 Port i_ready  input  1  downstream accept.
REQ-010 Port o_data  output  DW  stream payload.
REQ-011 Port o_last  output  1  final word of packet.
REQ-012 Port o_trunc  output  1  one-cycle pulse on packet truncation.
REQ-013 Port o_pkt_count  output  32  packets emitted (statistics).
REQ-014 Port o_drop_count  output  32  words discarded (statistics).

Function
REQ-015 A transfer completes on any cycle where o_valid and i_ready are both high; o_valid, o_data and o_last hold steady until that cycle.
REQ-016 Buffering is an output register plus a one-entry skid register.
REQ-017 In PASS state, o_rd = !i_rd_empty && !skid_valid; o_rd depends on no other combinational input path.
REQ-018 Popped word routing:
- to the output register when (!o_valid || i_ready);
- otherwise to the skid register.
REQ-019 When the output register frees and skid_valid is high, the skid word moves to the output register ahead of any new pop.
REQ-020 Latency: a word popped in cycle N appears on o_data in cycle N+1 when the output path is free.
REQ-021 Sustained throughput is one word per clock when i_ready stays high and the FIFO is non-empty.
REQ-022 States: PASS (forwarding) and DROP (discarding); reset state is PASS.
REQ-023 Length counter (LGMAXLEN+1 bits) counts words popped in PASS; it clears to 0 after a word with the last flag set is popped.
REQ-024 Truncation: when the (1<<LGMAXLEN)-th word of a packet is popped in PASS with last flag clear:
- it is emitted with o_last=1;
- o_trunc pulses for one cycle, the cycle after the pop;
- state moves to DROP.
REQ-025 A (1<<LGMAXLEN)-th word with last flag set is a normal packet end: no truncation, state stays PASS.
REQ-026 In DROP, o_rd = !i_rd_empty regardless of i_ready or skid state; popped words are never emitted.
REQ-027 DROP returns to PASS on the cycle after a popped word has its last flag set; the counter clears to 0 at the same point.
REQ-028 Words already in the output or skid register when DROP is entered are still delivered.

Reset
REQ-029 Asserting i_reset_n low, even mid-packet, forces within the same cycle:
- o_valid=0, skid_valid=0, o_rd=0, o_trunc=0;
- state PASS, counter 0, o_pkt_count=0, o_drop_count=0.
REQ-030 o_data and o_last are don't-care while o_valid=0.
REQ-031 The FIFO contents are not touched by reset; the first word popped after release starts a new packet.

Configuration
REQ-032 With FIFO_READER_STATS_EN defined:
- o_pkt_count increments on each transfer with o_last=1;
- o_drop_count increments on each word popped in DROP;
- both counters wrap modulo 2^32.
REQ-033 Without FIFO_READER_STATS_EN, o_pkt_count and o_drop_count are constant 0 and no counter logic is generated.

Verification
REQ-034 DW=8, LGMAXLEN=2, i_ready=1; FIFO holds 0x11, 0x22, 0x33+last -> o_data 0x11, 0x22, 0x33 on consecutive cycles; o_last only on 0x33; o_trunc never pulses.
REQ-035 FIFO holds 0x01..0x06 with last on 0x06 -> emitted 0x01..0x04 with o_last on 0x04; one o_trunc pulse; 0x05 and 0x06 popped but not emitted; o_drop_count=2 with the macro defined.
REQ-036 i_ready=0 for 5 cycles during a 3-word packet -> o_rd drops after 2 pops (output + skid); all 3 words are delivered in order after i_ready returns high, with none lost or duplicated.
REQ-037 Truncation while i_ready=0 -> the discard words are popped regardless of i_ready; the held 4th word still transfers with o_last=1.
REQ-038 i_reset_n pulsed low mid-packet with o_valid=1 -> o_valid=0 and o_rd=0 immediately; after release the next word is counted as word 1 of a new packet.
REQ-039 Exactly 4-word packet with last on word 4 -> no o_trunc; the next packet's first word is forwarded normally.
